// File: rtl/flash_prog_sequencer.sv
// Flash program sequencer: erases every sector the byte range touches,
// programs the range page by page from the receive buffer and can
// read-verify each page. Only one macro command is outstanding at a time.
module flash_prog_sequencer #(
  parameter int ADDR_W       = 32,
  parameter int LEN_W        = 32,
  parameter int PAGE_BYTES   = 256,
  parameter int SECTOR_BYTES = 4096,
  parameter int TIMEOUT_CYC  = 16777216
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [1:0]        i_mode,
  input  logic [ADDR_W-1:0] i_start_addr,
  input  logic [LEN_W-1:0]  i_data_len,
  input  logic [15:0]       i_buff_count,
  output logic [3:0]        o_cmd,
  output logic              o_cmd_valid,
  output logic [ADDR_W-1:0] o_cmd_addr,
  output logic [15:0]       o_cmd_len,
  input  logic              i_cmd_done,
  input  logic              i_cmd_err,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_error,
  output logic [1:0]        o_err_code,
  output logic [15:0]       o_sec_cnt,
  output logic [15:0]       o_pg_cnt
);

  localparam int PG_LG  = $clog2(PAGE_BYTES);
  localparam int SEC_LG = $clog2(SECTOR_BYTES);
  localparam int CNT_W  = $clog2(TIMEOUT_CYC) + 1;

  localparam logic [3:0] CMD_ERASE  = 4'hA;
  localparam logic [3:0] CMD_WRITE  = 4'hC;
  localparam logic [3:0] CMD_VERIFY = 4'hD;

  typedef enum logic [3:0] {
    S_IDLE, S_CALC, S_ERASE, S_WT_ERASE, S_WAIT_BUF, S_PROG,
    S_WT_PROG, S_VERIFY, S_WT_VERIFY, S_FINISH, S_FAIL
  } state_t;

  state_t              r_state;
  logic [1:0]          r_mode;
  logic [ADDR_W-1:0]   r_cur_addr;
  logic [LEN_W-1:0]    r_rem_len;
  logic [ADDR_W-1:0]   r_sec_addr;
  logic [LEN_W:0]      r_sec_rem;
  logic [CNT_W-1:0]    r_wait_cnt;

  logic [ADDR_W-1:0]   w_sec_base;
  logic [LEN_W:0]      w_span;
  logic [LEN_W:0]      w_nsec;
  logic [LEN_W-1:0]    w_room;
  logic [LEN_W-1:0]    w_chunk;
  logic                w_buf_ok;
  logic                w_last;
  logic                w_timeout;

  // Range geometry: sector span of the request and the next page-bounded chunk.
  always_comb begin
    w_sec_base = r_cur_addr & ~ADDR_W'(SECTOR_BYTES - 1);
    // One extra bit keeps offset + length from overflowing.
    w_span     = (LEN_W+1)'(r_rem_len) + (LEN_W+1)'(r_cur_addr[SEC_LG-1:0]);
    w_nsec     = (w_span >> SEC_LG) + (LEN_W+1)'(|w_span[SEC_LG-1:0]);
    w_room     = LEN_W'(PAGE_BYTES) - LEN_W'(r_cur_addr[PG_LG-1:0]);
    w_chunk    = (r_rem_len < w_room) ? r_rem_len : w_room;
    w_buf_ok   = LEN_W'(i_buff_count) >= w_chunk;
    w_last     = (r_rem_len == w_chunk);
    w_timeout  = (r_wait_cnt == CNT_W'(TIMEOUT_CYC - 1));
  end

  // Sequencer FSM; every output is registered and set on entry to its state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_mode      <= '0;
      r_cur_addr  <= '0;
      r_rem_len   <= '0;
      r_sec_addr  <= '0;
      r_sec_rem   <= '0;
      r_wait_cnt  <= '0;
      o_cmd       <= '0;
      o_cmd_valid <= 1'b0;
      o_cmd_addr  <= '0;
      o_cmd_len   <= '0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_error     <= 1'b0;
      o_err_code  <= '0;
      o_sec_cnt   <= '0;
      o_pg_cnt    <= '0;
    end else begin
      o_cmd_valid <= 1'b0;
      o_done      <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_mode     <= i_mode;
            r_cur_addr <= i_start_addr;
            r_rem_len  <= i_data_len;
            o_error    <= 1'b0;
            o_err_code <= '0;
            o_sec_cnt  <= '0;
            o_pg_cnt   <= '0;
            o_busy     <= 1'b1;
            r_state    <= S_CALC;
          end
        end
        S_CALC: begin
          r_sec_addr <= w_sec_base;
          r_sec_rem  <= w_nsec;
          if (r_rem_len == '0) begin
            o_done  <= 1'b1;
            r_state <= S_FINISH;
          end else if (r_mode == 2'd2) begin
            r_state <= S_WAIT_BUF;
          end else begin
            o_cmd       <= CMD_ERASE;
            o_cmd_addr  <= w_sec_base;
            o_cmd_len   <= '0;
            o_cmd_valid <= 1'b1;
            r_wait_cnt  <= '0;
            r_state     <= S_ERASE;
          end
        end
        S_ERASE:  r_state <= S_WT_ERASE;
        S_WT_ERASE: begin
          if (i_cmd_done) begin
            if (i_cmd_err) begin
              o_error    <= 1'b1;
              o_err_code <= 2'd1;
              r_state    <= S_FAIL;
            end else begin
              o_sec_cnt  <= o_sec_cnt + 16'd1;
              r_sec_addr <= r_sec_addr + ADDR_W'(SECTOR_BYTES);
              r_sec_rem  <= r_sec_rem - 1'b1;
              if (r_sec_rem == (LEN_W+1)'(1)) begin
                if (r_mode == 2'd1) begin
                  o_done  <= 1'b1;
                  r_state <= S_FINISH;
                end else begin
                  r_state <= S_WAIT_BUF;
                end
              end else begin
                o_cmd_addr  <= r_sec_addr + ADDR_W'(SECTOR_BYTES);
                o_cmd_valid <= 1'b1;
                r_wait_cnt  <= '0;
                r_state     <= S_ERASE;
              end
            end
          end else if (w_timeout) begin
            o_error    <= 1'b1;
            o_err_code <= 2'd2;
            r_state    <= S_FAIL;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end
        S_WAIT_BUF: begin
          if (w_buf_ok) begin
            o_cmd       <= CMD_WRITE;
            o_cmd_addr  <= r_cur_addr;
            o_cmd_len   <= 16'(w_chunk);
            o_cmd_valid <= 1'b1;
            r_wait_cnt  <= '0;
            r_state     <= S_PROG;
          end
        end
        S_PROG:   r_state <= S_WT_PROG;
        S_WT_PROG: begin
          if (i_cmd_done) begin
            if (i_cmd_err) begin
              o_error    <= 1'b1;
              o_err_code <= 2'd1;
              r_state    <= S_FAIL;
            end else if (r_mode == 2'd3) begin
              // Address and length registers still hold the write's values.
              o_cmd       <= CMD_VERIFY;
              o_cmd_valid <= 1'b1;
              r_wait_cnt  <= '0;
              r_state     <= S_VERIFY;
            end else begin
              o_pg_cnt   <= o_pg_cnt + 16'd1;
              r_cur_addr <= r_cur_addr + ADDR_W'(w_chunk);
              r_rem_len  <= r_rem_len - w_chunk;
              o_done     <= w_last;
              r_state    <= w_last ? S_FINISH : S_WAIT_BUF;
            end
          end else if (w_timeout) begin
            o_error    <= 1'b1;
            o_err_code <= 2'd2;
            r_state    <= S_FAIL;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end
        S_VERIFY: r_state <= S_WT_VERIFY;
        S_WT_VERIFY: begin
          if (i_cmd_done) begin
            if (i_cmd_err) begin
              o_error    <= 1'b1;
              o_err_code <= 2'd1;
              r_state    <= S_FAIL;
            end else begin
              o_pg_cnt   <= o_pg_cnt + 16'd1;
              r_cur_addr <= r_cur_addr + ADDR_W'(w_chunk);
              r_rem_len  <= r_rem_len - w_chunk;
              o_done     <= w_last;
              r_state    <= w_last ? S_FINISH : S_WAIT_BUF;
            end
          end else if (w_timeout) begin
            o_error    <= 1'b1;
            o_err_code <= 2'd2;
            r_state    <= S_FAIL;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end
        S_FINISH, S_FAIL: begin
          o_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default:  r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_flash_prog_sequencer.sv
// Directed bench for flash_prog_sequencer: a range-level model lists the
// commands each request must produce; a negedge process compares every strobe
// and acts as the flash engine (latency, error injection, withheld done).
module tb_flash_prog_sequencer;
  localparam int PB = 256;
  localparam int SB = 4096;
  localparam int TO = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  mode = '0;
  logic [31:0] saddr = '0;
  logic [31:0] dlen = '0;
  logic [15:0] buff = 16'd256;
  logic        cmd_done = 1'b0;
  logic        cmd_err = 1'b0;
  logic [3:0]  o_cmd;
  logic        o_cmd_valid;
  logic [31:0] o_cmd_addr;
  logic [15:0] o_cmd_len;
  logic        o_busy, o_done, o_error;
  logic [1:0]  o_err_code;
  logic [15:0] o_sec_cnt, o_pg_cnt;

  always #5 clk = ~clk;

  flash_prog_sequencer #(
    .ADDR_W(32), .LEN_W(32), .PAGE_BYTES(PB), .SECTOR_BYTES(SB), .TIMEOUT_CYC(TO)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_mode(mode),
    .i_start_addr(saddr), .i_data_len(dlen), .i_buff_count(buff),
    .o_cmd(o_cmd), .o_cmd_valid(o_cmd_valid), .o_cmd_addr(o_cmd_addr),
    .o_cmd_len(o_cmd_len), .i_cmd_done(cmd_done), .i_cmd_err(cmd_err),
    .o_busy(o_busy), .o_done(o_done), .o_error(o_error), .o_err_code(o_err_code),
    .o_sec_cnt(o_sec_cnt), .o_pg_cnt(o_pg_cnt)
  );

  typedef struct { logic [3:0] c; logic [31:0] a; logic [15:0] l; } ent_t;
  ent_t exp_q[$];

  int n_chk = 0, n_pass = 0;
  int cyc = 0;
  int exp_done, exp_err, exp_code, exp_sec, exp_pg;
  int inj = -1, hold = 0, lat = 3;
  int seen, done_cnt, eng_idx, pend;
  int t_start, t_done, t_strobe, t_err;
  bit pend_err, outstanding, prev_err;
  ent_t held;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h", nm, got, want);
  endtask

  function automatic void push_ent(input logic [3:0] c, input longint a, input longint l);
    ent_t e;
    e.c = c; e.a = 32'(a); e.l = 16'(l);
    exp_q.push_back(e);
  endfunction

  // Expected command stream from the range rules: every sector touched by
  // [a, a+l), then page-bounded chunks (each followed by a verify in mode 3).
  function automatic void build(input int m, input longint a, input longint l, input int f);
    longint p, r, c, s0, s1;
    int n;
    exp_q.delete();
    if (l != 0) begin
      if (m != 2) begin
        s0 = (a / SB) * SB;
        s1 = ((a + l - 1) / SB) * SB;
        for (longint s = s0; s <= s1; s += SB) push_ent(4'hA, s, 0);
      end
      if (m != 1) begin
        p = a; r = l;
        while (r > 0) begin
          c = PB - (p % PB);
          if (c > r) c = r;
          push_ent(4'hC, p, c);
          if (m == 3) push_ent(4'hD, p, c);
          p = (p + c) % 64'h1_0000_0000;
          r -= c;
        end
      end
    end
    if (f >= 0) while (exp_q.size() > f + 1) void'(exp_q.pop_back());
    n = (f >= 0) ? f : exp_q.size();
    exp_sec = 0; exp_pg = 0;
    for (int i = 0; i < n; i++) begin
      if (exp_q[i].c == 4'hA) exp_sec++;
      if (exp_q[i].c == ((m == 3) ? 4'hD : 4'hC)) exp_pg++;
    end
    exp_done = (f < 0) ? 1 : 0;
    exp_err  = (f < 0) ? 0 : 1;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Compare process plus flash engine model.
  always @(negedge clk) begin
    if (rst) begin
      outstanding = 0; pend = 0; cmd_done = 0; cmd_err = 0;
    end else begin
      if (o_cmd_valid) begin
        if (seen < exp_q.size()) begin
          chk("cmd_code", o_cmd, exp_q[seen].c);
          chk("cmd_addr", o_cmd_addr, exp_q[seen].a);
          chk("cmd_len", o_cmd_len, exp_q[seen].l);
        end else chk("extra_cmd", seen, exp_q.size());
        if (seen == 0) t_strobe = cyc;
        seen++;
        outstanding = 1;
        held.c = o_cmd; held.a = o_cmd_addr; held.l = o_cmd_len;
      end else if (outstanding && o_busy) begin
        chk("cmd_stable", {o_cmd, o_cmd_addr, o_cmd_len}, {held.c, held.a, held.l});
      end
      if (!o_busy) outstanding = 0;
      if (o_done) begin done_cnt++; t_done = cyc; end
      if (o_error && !prev_err) t_err = cyc;
      prev_err = o_error;
      cmd_done = 0; cmd_err = 0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin cmd_done = 1; cmd_err = pend_err; outstanding = 0; end
      end
      if (o_cmd_valid) begin
        if (!(hold != 0 && eng_idx == 0)) begin pend = lat; pend_err = (eng_idx == inj); end
        eng_idx++;
      end
    end
  end

  task automatic start_op(input int m, input logic [31:0] a, input logic [31:0] l,
                          input int inj_i, input int hold_i);
    build(m, a, l, (hold_i != 0) ? 0 : inj_i);
    exp_code = (hold_i != 0) ? 2 : ((inj_i >= 0) ? 1 : 0);
    inj = inj_i; hold = hold_i;
    seen = 0; done_cnt = 0; eng_idx = 0; pend = 0;
    t_done = -1; t_err = -1; t_strobe = -1;
    @(negedge clk);
    mode = m[1:0]; saddr = a; dlen = l; start = 1'b1; t_start = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic finish_op(input int maxcyc, input string tag);
    int n = 0;
    while (o_busy && n < maxcyc) begin @(negedge clk); n++; end
    chk({tag, "_idle"}, o_busy, 0);
    chk({tag, "_ncmd"}, seen, exp_q.size());
    chk({tag, "_done"}, done_cnt, exp_done);
    chk({tag, "_error"}, o_error, exp_err);
    chk({tag, "_errcode"}, o_err_code, exp_code);
    chk({tag, "_sec"}, o_sec_cnt, exp_sec);
    chk({tag, "_pg"}, o_pg_cnt, exp_pg);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_valid", o_cmd_valid, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_outs", {o_cmd, o_cmd_addr, o_cmd_len, o_done, o_error, o_err_code}, 0);
    chk("rst_cnts", {o_sec_cnt, o_pg_cnt}, 0);
    rst = 1'b0;

    // Full sector, full pages.
    lat = 3;
    start_op(0, 32'h0, 32'd4096, -1, 0);
    finish_op(2000, "t1");
    chk("t1_lit_n", exp_q.size(), 17);
    chk("t1_lit_last", exp_q[16].a, 32'hF00);
    chk("t1_lit_sec", o_sec_cnt, 1);
    chk("t1_lit_pg", o_pg_cnt, 16);

    // Range straddles a sector boundary with partial first/last pages.
    start_op(0, 32'hF80, 32'd512, -1, 0);
    finish_op(500, "t2");
    chk("t2_lit_e1", exp_q[1].a, 32'h1000);
    chk("t2_lit_w0", {exp_q[2].a, exp_q[2].l}, {32'hF80, 16'd128});
    chk("t2_lit_w2", {exp_q[4].a, exp_q[4].l}, {32'h1100, 16'd128});
    chk("t2_lit_pg", o_pg_cnt, 3);

    // Verify reports a mismatch.
    lat = 1;
    start_op(3, 32'h2000, 32'd256, 2, 0);
    finish_op(500, "t3");
    chk("t3_lit_seq", {exp_q[0].c, exp_q[1].c, exp_q[2].c}, 12'hACD);
    chk("t3_lit_err", {o_error, o_err_code}, 3'b101);
    chk("t3_lit_done", done_cnt, 0);

    // Program waits for the buffer to fill.
    lat = 2; buff = 16'd100;
    start_op(2, 32'h0, 32'd300, -1, 0);
    repeat (50) @(negedge clk);
    chk("t4_no_write", seen, 0);
    buff = 16'd256;
    finish_op(500, "t4");
    chk("t4_lit_tail", exp_q[1].l, 44);

    // Engine never answers the erase.
    start_op(0, 32'h0, 32'd16, -1, 1);
    finish_op(500, "t5");
    chk("t5_lit_code", o_err_code, 2);
    chk("t5_to_lat", ((t_err - t_strobe) >= TO) && ((t_err - t_strobe) <= TO + 2), 1);

    // Zero length: no commands, done two cycles after start; error cleared.
    start_op(2, 32'h40, 32'd0, -1, 0);
    chk("t6_err_clr", {o_error, o_err_code}, 0);
    finish_op(100, "t6");
    chk("t6_done_lat", t_done - t_start, 2);

    // Erase only across three sectors.
    lat = 3;
    start_op(1, 32'h1234, 32'h2000, -1, 0);
    finish_op(500, "t7");
    chk("t7_lit_last", exp_q[2].a, 32'h3000);
    chk("t7_lit_sec", o_sec_cnt, 3);

    // Address wraps past the top of the space.
    start_op(2, 32'hFFFF_FF80, 32'h100, -1, 0);
    finish_op(500, "t8");
    chk("t8_lit_wrap", {exp_q[1].a, exp_q[1].l}, {32'h0, 16'd128});

    // Reset while a write is outstanding.
    lat = 8;
    start_op(2, 32'h300, 32'd256, -1, 0);
    for (int i = 0; i < 100 && seen == 0; i++) @(negedge clk);
    chk("t9_write_seen", seen, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t9_rst_outs", {o_cmd, o_cmd_valid, o_cmd_addr, o_cmd_len, o_busy, o_done}, 0);
    chk("t9_rst_stat", {o_error, o_err_code, o_sec_cnt, o_pg_cnt}, 0);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("t9_no_done", done_cnt, 0);
    chk("t9_idle", o_busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/flash_prog_sequencer.md
Name: flash_prog_sequencer

Overview:
Parametrised successor of the UART-driven flash macro sequencer. Given a start address, byte length and mode, it erases every 4 kB-class sector the range touches, programs the range page by page from the UART receive buffer (first/last pages may be partial), and optionally read-verifies each page. It issues one macro command at a time to the flash engine and reports progress, done and error.

Parameters:
ADDR_W, 32, flash byte-address width
LEN_W, 32, data length width
PAGE_BYTES, 256, program page size; power of two
SECTOR_BYTES, 4096, erase sector size; power of two, multiple of PAGE_BYTES
TIMEOUT_CYC, 16777216, max cycles waiting for any cmd_done

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  one-cycle request; sampled only in IDLE
mode  in  2  0 erase+program, 1 erase only, 2 program only, 3 erase+program+verify
start_addr  in  ADDR_W  first byte address, latched on start
data_len  in  LEN_W  byte count, latched on start
buff_count  in  16  bytes currently held in program buffer
cmd  out  4  macro command: 4'hA erase sector, 4'hC write page, 4'hD read/verify page
cmd_valid  out  1  one-cycle command strobe
cmd_addr  out  ADDR_W  command address
cmd_len  out  16  bytes for write/verify (0 for erase)
cmd_done  in  1  flash engine completion pulse
cmd_err  in  1  engine error/verify-mismatch, qualified by cmd_done
busy  out  1  high outside IDLE
done  out  1  one-cycle pulse on successful completion
error  out  1  sticky until next accepted start
err_code  out  2  1 engine error, 2 timeout, 3 reserved
sec_cnt  out  16  sectors erased so far
pg_cnt  out  16  pages programmed so far

Behaviour:
- Clock is clk; reset is synchronous, active-high (rst). Reset: all outputs 0, state IDLE; reset mid-operation abandons the current command without a done pulse.
- States: IDLE, CALC, ERASE, WT_ERASE, WAIT_BUF, PROG, WT_PROG, VERIFY, WT_VERIFY, FINISH, FAIL.
- IDLE: start=1 -> latch addr/len/mode, clear error/err_code/sec_cnt/pg_cnt -> CALC. start while busy ignored.
- CALC (1 cycle): sec_addr = start_addr with low log2(SECTOR_BYTES) bits cleared; n_sec = ceil(((start_addr mod SECTOR_BYTES) + data_len) / SECTOR_BYTES) computed in LEN_W+1 bits, no overflow. data_len=0 -> FINISH, no commands. mode 2 -> WAIT_BUF, else ERASE.
- ERASE: cmd=4'hA, cmd_addr=sec_addr, cmd_valid for 1 cycle -> WT_ERASE. On cmd_done: sec_cnt++, sec_addr += SECTOR_BYTES; remaining sectors 0 -> (mode 1 ? FINISH : WAIT_BUF) else ERASE.
- Chunk = min(remaining_len, PAGE_BYTES - (cur_addr mod PAGE_BYTES)); cur_addr starts at start_addr.
- WAIT_BUF: stay until buff_count >= chunk -> PROG. PROG: cmd=4'hC, cmd_addr=cur_addr, cmd_len=chunk, strobe -> WT_PROG.
- WT_PROG on cmd_done: mode 3 -> VERIFY (same addr/len, cmd=4'hD) -> WT_VERIFY; else advance. Advance: pg_cnt++, cur_addr += chunk, remaining -= chunk; remaining 0 -> FINISH else WAIT_BUF.
- cmd_done in the same cycle as cmd_valid is ignored; only wait states accept it. cmd, cmd_addr, cmd_len hold stable from strobe until cmd_done.
- Any wait state: cmd_done with cmd_err=1 -> FAIL, err_code=1. Wait counter reaching TIMEOUT_CYC-1 without cmd_done -> FAIL, err_code=2. Counter clears on every strobe.
- FINISH: done=1 one cycle -> IDLE. FAIL: error=1 (sticky), no done -> IDLE.
- Address arithmetic wraps modulo 2^ADDR_W.

Test Plan:
- mode 0, addr 0x000000, len 4096, buff_count 256: one erase @0x0, then 16 writes @0x000..0xF00 len 256; sec_cnt=1, pg_cnt=16, done once.
- mode 0, addr 0x000F80, len 512: erases @0x0000 and @0x1000; writes (0xF80,128),(0x1000,256),(0x1100,128); pg_cnt=3.
- mode 3, addr 0x2000, len 256; cmd_err=1 on the verify cmd_done: sequence A,C,D, then error=1, err_code=1, no done.
- mode 2, len 300, buff_count held at 100 for 50 cycles then 256: no write issued before buff_count reaches 256; writes of 256 then 44.
- cmd_done withheld after erase strobe: FAIL at TIMEOUT_CYC (set 64 in bench), err_code=2; next start clears error.
- data_len=0 -> done 2 cycles after start, no cmd_valid; rst asserted mid-WT_PROG -> all outputs 0 next cycle.
